// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stage rst/en sequencing, hazard stalls, flushes, forwarding and perf counters for a 5-stage MIPS pipe
module pipeline_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       addr_rs_id,
    input  logic [4:0]       addr_rt_id,
    input  logic             rs_used_id,
    input  logic             rt_used_id,
    input  logic [4:0]       regw_addr_exe,
    input  logic             wb_wen_exe,
    input  logic             mem_ren_exe,
    input  logic [4:0]       regw_addr_mem,
    input  logic             wb_wen_mem,
    input  logic             mem_ren_mem,
    input  logic             mem_wen_mem,
    input  logic             is_branch_mem,
    input  logic             mem_ack,
    output logic             if_rst,
    output logic             if_en,
    output logic             id_rst,
    output logic             id_en,
    output logic             exe_rst,
    output logic             exe_en,
    output logic             mem_rst,
    output logic             mem_en,
    output logic             wb_rst,
    output logic             wb_en,
    output logic [1:0]       forwards,
    output logic [1:0]       forwardt,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {INIT, RUN, MEMWAIT} state_t;
    state_t state_q, state_d;
    logic [7:0] init_q, init_d, timer_q, timer_d;
    logic fault_q, fault_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic memreq, hazard, active, rel, mem_stall;
    logic [4:0] en, rs;

    // A matching load still in EXE has no data yet; it is picked up from MEM next cycle
    function automatic logic [1:0] fwd(input logic used, input logic [4:0] a,
                                       input logic [4:0] ae, input logic we, input logic le,
                                       input logic [4:0] am, input logic wm, input logic lm);
        if (!used || a == 5'd0) return 2'd0;
        if (we && a == ae) return le ? 2'd0 : 2'd1;
        if (wm && a == am) return lm ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        memreq = mem_ren_mem | mem_wen_mem;
        hazard = mem_ren_exe & wb_wen_exe & (regw_addr_exe != 5'd0) &
                 ((rs_used_id & (addr_rs_id == regw_addr_exe)) | (rt_used_id & (addr_rt_id == regw_addr_exe)));
        active = !rst && state_q != INIT;
        rel = state_q == MEMWAIT && (mem_ack || timer_q == 8'(MEM_TIMEOUT));
        mem_stall = state_q == MEMWAIT ? !rel : state_q == RUN && memreq && !mem_ack;
        state_d = state_q;
        init_d = init_q;
        timer_d = timer_q;
        fault_d = fault_q;
        stall_d = stall_q;
        flush_d = flush_q;
        en = '0;
        rs = '1;
        if (state_q == INIT) begin
            init_d = init_q + 8'd1;
            state_d = init_q == 8'(INIT_CYCLES - 1) ? RUN : INIT;
        end else if (mem_stall) begin
            rs = 5'b00001;
            state_d = MEMWAIT;
            timer_d = state_q == RUN ? 8'd1 : timer_q + 8'd1;
            stall_d = &stall_q ? stall_q : stall_q + 1'b1;
        end else begin
            state_d = RUN;
            fault_d = fault_q | (rel & !mem_ack);
            en = hazard && !is_branch_mem ? 5'b00111 : 5'b11111;
            rs = is_branch_mem ? 5'b01110 : hazard ? 5'b00100 : 5'b00000;
            flush_d = is_branch_mem && !(&flush_q) ? flush_q + 1'b1 : flush_q;
            stall_d = hazard && !is_branch_mem && !(&stall_q) ? stall_q + 1'b1 : stall_q;
        end
        if (rst) begin
            en = '0;
            rs = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            init_q <= '0;
            timer_q <= '0;
            fault_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            init_q <= init_d;
            timer_q <= timer_d;
            fault_q <= fault_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign {if_en, id_en, exe_en, mem_en, wb_en} = en;
    assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = rs;
    assign forwards = active ? fwd(rs_used_id, addr_rs_id, regw_addr_exe, wb_wen_exe, mem_ren_exe,
                                   regw_addr_mem, wb_wen_mem, mem_ren_mem) : 2'd0;
    assign forwardt = active ? fwd(rt_used_id, addr_rt_id, regw_addr_exe, wb_wen_exe, mem_ren_exe,
                                   regw_addr_mem, wb_wen_mem, mem_ren_mem) : 2'd0;
    assign mem_fault = fault_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized run against a cycle-level behavioural model
module tb_pipeline_ctrl;
    localparam int INIT_CYCLES = 4;
    localparam int MEM_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] addr_rs_id, addr_rt_id, regw_addr_exe, regw_addr_mem;
    logic rs_used_id, rt_used_id, wb_wen_exe, mem_ren_exe, wb_wen_mem, mem_ren_mem, mem_wen_mem;
    logic is_branch_mem, mem_ack;
    wire [4:0] en_v, rs_v, s_en, s_rs;
    wire [1:0] forwards, forwardt, s_fs, s_ft;
    wire mem_fault, s_fault;
    wire [15:0] stall_cnt, flush_cnt;
    wire [2:0] s_stall, s_flush;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .addr_rs_id(addr_rs_id), .addr_rt_id(addr_rt_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id), .regw_addr_exe(regw_addr_exe),
        .wb_wen_exe(wb_wen_exe), .mem_ren_exe(mem_ren_exe), .regw_addr_mem(regw_addr_mem),
        .wb_wen_mem(wb_wen_mem), .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem),
        .is_branch_mem(is_branch_mem), .mem_ack(mem_ack),
        .if_rst(rs_v[4]), .if_en(en_v[4]), .id_rst(rs_v[3]), .id_en(en_v[3]),
        .exe_rst(rs_v[2]), .exe_en(en_v[2]), .mem_rst(rs_v[1]), .mem_en(en_v[1]),
        .wb_rst(rs_v[0]), .wb_en(en_v[0]), .forwards(forwards), .forwardt(forwardt),
        .mem_fault(mem_fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .addr_rs_id(addr_rs_id), .addr_rt_id(addr_rt_id),
        .rs_used_id(rs_used_id), .rt_used_id(rt_used_id), .regw_addr_exe(regw_addr_exe),
        .wb_wen_exe(wb_wen_exe), .mem_ren_exe(mem_ren_exe), .regw_addr_mem(regw_addr_mem),
        .wb_wen_mem(wb_wen_mem), .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem),
        .is_branch_mem(is_branch_mem), .mem_ack(mem_ack),
        .if_rst(s_rs[4]), .if_en(s_en[4]), .id_rst(s_rs[3]), .id_en(s_en[3]),
        .exe_rst(s_rs[2]), .exe_en(s_en[2]), .mem_rst(s_rs[1]), .mem_en(s_en[1]),
        .wb_rst(s_rs[0]), .wb_en(s_en[0]), .forwards(s_fs), .forwardt(s_ft),
        .mem_fault(s_fault), .stall_cnt(s_stall), .flush_cnt(s_flush)
    );

    task automatic idle();
        rst = 1'b0;
        {addr_rs_id, addr_rt_id, regw_addr_exe, regw_addr_mem} = '0;
        {rs_used_id, rt_used_id, wb_wen_exe, mem_ren_exe, wb_wen_mem} = '0;
        {mem_ren_mem, mem_wen_mem, is_branch_mem, mem_ack} = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (INIT_CYCLES) @(negedge clk);
    endtask

    function automatic logic [1:0] mfwd(input logic used, input logic [4:0] a);
        if (!used || a == 5'd0) return 2'd0;
        if (wb_wen_exe && a == regw_addr_exe) return mem_ren_exe ? 2'd0 : 2'd1;
        if (wb_wen_mem && a == regw_addr_mem) return mem_ren_mem ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    task automatic test_reset();
        logic [4:0] e_en, e_rs;
        @(negedge clk);
        idle();
        rst = 1'b1;
        rs_used_id = 1'b1; addr_rs_id = 5'd3; wb_wen_exe = 1'b1; regw_addr_exe = 5'd3;
        #1;
        checks++;
        if (en_v !== 5'b0 || rs_v !== 5'b11111) begin
            failures++;
            $display("FAIL reset_outputs en=%b rst=%b want en=00000 rst=11111", en_v, rs_v);
        end
        checks++;
        if (forwards !== 2'd0) begin
            failures++;
            $display("FAIL reset_forwards got=%0d want=0", forwards);
        end
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || mem_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs stall=%0d flush=%0d fault=%b want 0 0 0", stall_cnt, flush_cnt, mem_fault);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= INIT_CYCLES + 1; k++) begin
            #1;
            e_en = k > INIT_CYCLES ? 5'b11111 : 5'b00000;
            e_rs = k > INIT_CYCLES ? 5'b00000 : 5'b11111;
            checks++;
            if (en_v !== e_en || rs_v !== e_rs || forwards !== (k > INIT_CYCLES ? 2'd1 : 2'd0)) begin
                failures++;
                $display("FAIL init_seq cycle=%0d en=%b rst=%b fs=%0d want en=%b rst=%b", k, en_v, rs_v, forwards, e_en, e_rs);
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_load_use();
        reset_dut();
        mem_ren_exe = 1'b1; wb_wen_exe = 1'b1; regw_addr_exe = 5'd8; rs_used_id = 1'b1; addr_rs_id = 5'd8;
        #1;
        checks++;
        if (en_v[4:3] !== 2'b00 || rs_v[2] !== 1'b1 || en_v[1:0] !== 2'b11 || forwards !== 2'd0) begin
            failures++;
            $display("FAIL load_use_stall en=%b rst=%b fs=%0d want en=00x11 exe_rst=1 fs=0", en_v, rs_v, forwards);
        end
        @(negedge clk);
        mem_ren_exe = 1'b0; wb_wen_exe = 1'b0; regw_addr_exe = 5'd0;
        regw_addr_mem = 5'd8; wb_wen_mem = 1'b1; mem_ren_mem = 1'b1; mem_ack = 1'b1;
        #1;
        checks++;
        if (forwards !== 2'd3 || stall_cnt !== 16'd1 || en_v !== 5'b11111) begin
            failures++;
            $display("FAIL load_use_after fs=%0d stall=%0d en=%b want 3 1 11111", forwards, stall_cnt, en_v);
        end
        idle();
    endtask

    task automatic test_forwarding();
        reset_dut();
        wb_wen_exe = 1'b1; regw_addr_exe = 5'd5; wb_wen_mem = 1'b1; regw_addr_mem = 5'd5;
        rt_used_id = 1'b1; addr_rt_id = 5'd5; addr_rs_id = 5'd5;
        #1;
        checks++;
        if (forwardt !== 2'd1 || forwards !== 2'd0) begin
            failures++;
            $display("FAIL fwd_exe ft=%0d fs=%0d want 1 0", forwardt, forwards);
        end
        regw_addr_exe = 5'd6;
        #1;
        checks++;
        if (forwardt !== 2'd2) begin
            failures++;
            $display("FAIL fwd_mem ft=%0d want 2", forwardt);
        end
        mem_ren_mem = 1'b1; mem_ack = 1'b1;
        #1;
        checks++;
        if (forwardt !== 2'd3) begin
            failures++;
            $display("FAIL fwd_mem_load ft=%0d want 3", forwardt);
        end
        addr_rt_id = 5'd0; regw_addr_exe = 5'd0; regw_addr_mem = 5'd0;
        #1;
        checks++;
        if (forwardt !== 2'd0) begin
            failures++;
            $display("FAIL fwd_zero ft=%0d want 0", forwardt);
        end
        idle();
    endtask

    task automatic test_branch_vs_loaduse();
        reset_dut();
        mem_ren_exe = 1'b1; wb_wen_exe = 1'b1; regw_addr_exe = 5'd9; rt_used_id = 1'b1; addr_rt_id = 5'd9;
        is_branch_mem = 1'b1;
        #1;
        checks++;
        if (rs_v !== 5'b01110 || en_v !== 5'b11111) begin
            failures++;
            $display("FAIL branch_flush en=%b rst=%b want 11111 01110", en_v, rs_v);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL branch_counts flush=%0d stall=%0d want 1 0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        reset_dut();
        mem_ren_mem = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (en_v !== 5'b0 || rs_v !== 5'b00001) begin
                failures++;
                $display("FAIL mem_wait cycle=%0d en=%b rst=%b want 00000 00001", k, en_v, rs_v);
            end
            @(negedge clk);
        end
        mem_ack = 1'b1;
        #1;
        checks++;
        if (en_v !== 5'b11111 || rs_v !== 5'b0) begin
            failures++;
            $display("FAIL mem_ack_release en=%b rst=%b want 11111 00000", en_v, rs_v);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (stall_cnt !== 16'd3 || mem_fault !== 1'b0 || en_v !== 5'b11111) begin
            failures++;
            $display("FAIL mem_wait_after stall=%0d fault=%b en=%b want 3 0 11111", stall_cnt, mem_fault, en_v);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit released = 0;
        reset_dut();
        mem_ren_mem = 1'b1;
        for (int c = 0; c < 40 && !released; c++) begin
            #1;
            if (en_v == 5'b0) n++;
            else released = 1;
            @(negedge clk);
        end
        idle();
        #1;
        checks++;
        if (!released || n != MEM_TIMEOUT) begin
            failures++;
            $display("FAIL timeout_len released=%0d waited=%0d want 1 %0d", released, n, MEM_TIMEOUT);
        end
        checks++;
        if (mem_fault !== 1'b1 || stall_cnt !== 16'(MEM_TIMEOUT) || en_v !== 5'b11111) begin
            failures++;
            $display("FAIL timeout_fault fault=%b stall=%0d en=%b want 1 %0d 11111", mem_fault, stall_cnt, en_v, MEM_TIMEOUT);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mem_fault !== 1'b1) begin
            failures++;
            $display("FAIL fault_sticky fault=%b want 1", mem_fault);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_clear fault=%b want 0", mem_fault);
        end
        idle();
    endtask

    task automatic test_random(input int n);
        int m_init, m_wait, m_stall, m_flush, thr;
        logic m_fault, hz, wt, mst;
        logic [4:0] e_en, e_rs;
        logic [1:0] e_fs, e_ft;
        reset_dut();
        m_init = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_fault = 1'b0;
        for (int i = 0; i < n; i++) begin
            thr = (i / 300) % 3 == 0 ? 6 : (i / 300) % 3 == 1 ? 1 : 0;
            rst = i < n - 500 && $urandom_range(0, 199) == 0;
            addr_rs_id = 5'($urandom_range(0, 3));
            addr_rt_id = 5'($urandom_range(0, 3));
            regw_addr_exe = 5'($urandom_range(0, 3));
            regw_addr_mem = 5'($urandom_range(0, 3));
            rs_used_id = 1'($urandom_range(0, 1));
            rt_used_id = 1'($urandom_range(0, 1));
            wb_wen_exe = 1'($urandom_range(0, 1));
            wb_wen_mem = 1'($urandom_range(0, 1));
            mem_ren_exe = $urandom_range(0, 2) == 0;
            mem_ren_mem = $urandom_range(0, 4) == 0;
            mem_wen_mem = $urandom_range(0, 7) == 0;
            is_branch_mem = $urandom_range(0, 7) == 0;
            mem_ack = $urandom_range(0, 7) < thr;
            #1;
            hz = mem_ren_exe && wb_wen_exe && regw_addr_exe != 0 &&
                 ((rs_used_id && addr_rs_id == regw_addr_exe) || (rt_used_id && addr_rt_id == regw_addr_exe));
            wt = m_wait > 0;
            mst = wt ? (!mem_ack && m_wait < MEM_TIMEOUT) : ((mem_ren_mem || mem_wen_mem) && !mem_ack);
            e_fs = 2'd0;
            e_ft = 2'd0;
            if (rst || m_init > 0) begin
                e_en = 5'b00000; e_rs = 5'b11111;
            end else begin
                e_fs = mfwd(rs_used_id, addr_rs_id);
                e_ft = mfwd(rt_used_id, addr_rt_id);
                if (mst) begin e_en = 5'b00000; e_rs = 5'b00001; end
                else if (is_branch_mem) begin e_en = 5'b11111; e_rs = 5'b01110; end
                else if (hz) begin e_en = 5'b00111; e_rs = 5'b00100; end
                else begin e_en = 5'b11111; e_rs = 5'b00000; end
            end
            checks++;
            if (en_v !== e_en || rs_v !== e_rs) begin
                failures++;
                $display("FAIL rand_stage i=%0d en=%b rst=%b want en=%b rst=%b", i, en_v, rs_v, e_en, e_rs);
            end
            checks++;
            if (forwards !== e_fs || forwardt !== e_ft) begin
                failures++;
                $display("FAIL rand_fwd i=%0d fs=%0d ft=%0d want %0d %0d", i, forwards, forwardt, e_fs, e_ft);
            end
            checks++;
            if (mem_fault !== m_fault || stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
                failures++;
                $display("FAIL rand_regs i=%0d fault=%b stall=%0d flush=%0d want %b %0d %0d", i, mem_fault, stall_cnt, flush_cnt, m_fault, m_stall, m_flush);
            end
            checks++;
            if (s_stall !== 3'(m_stall > 7 ? 7 : m_stall) || s_flush !== 3'(m_flush > 7 ? 7 : m_flush)) begin
                failures++;
                $display("FAIL rand_sat i=%0d stall=%0d flush=%0d want %0d %0d", i, s_stall, s_flush, m_stall > 7 ? 7 : m_stall, m_flush > 7 ? 7 : m_flush);
            end
            if (rst) begin
                m_init = INIT_CYCLES; m_wait = 0; m_stall = 0; m_flush = 0; m_fault = 1'b0;
            end else if (m_init > 0) m_init--;
            else if (mst) begin
                m_wait++;
                m_stall++;
            end else begin
                if (wt && !mem_ack) m_fault = 1'b1;
                m_wait = 0;
                if (is_branch_mem) m_flush++;
                else if (hz) m_stall++;
            end
            @(negedge clk);
        end
        idle();
        checks++;
        if (s_stall !== 3'd7 || s_flush !== 3'd7) begin
            failures++;
            $display("FAIL saturate stall=%0d flush=%0d want 7 7", s_stall, s_flush);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch_vs_loaduse();
        test_mem_wait();
        test_timeout();
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
